// File: rtl/totient_pkg.sv
// Shared definitions for the Euler-totient sequencer slice.
//   - state_e   : sequencer FSM states
//   - SEG_TBL   : hex -> ABCDEFG segment patterns (bit 6 = A ... bit 0 = G, 1 = lit)
//   - TOT_N_W   : default width of n, k, count and phi
package totient_pkg;

  localparam int TOT_N_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_GCD = 2'd2,
    EMIT     = 2'd3
  } state_e;

  // Index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_TBL = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,  // F E d C
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,  // b A 9 8
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,  // 7 6 5 4
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110   // 3 2 1 0
  };

endpackage

// File: rtl/totient_gcd_unit.sv
// Iterative subtractive GCD engine.
// Ports:
//   clk_0, R      : clock, asynchronous active-high reset
//   start, a, b   : load operands (both must be nonzero) and become active
//   done          : combinational, high while active and a == b
//   gcd           : result, valid while done
// The engine drops out of the active state on the cycle after done.
module totient_gcd_unit
  import totient_pkg::*;
#(
  parameter int N_W = TOT_N_W
) (
  input  logic           clk_0,
  input  logic           R,
  input  logic           start,
  input  logic [N_W-1:0] a,
  input  logic [N_W-1:0] b,
  output logic           done,
  output logic [N_W-1:0] gcd
);

  logic           active_q;
  logic [N_W-1:0] a_q, b_q;

  always_ff @(posedge clk_0 or posedge R) begin
    if (R) begin
      active_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      a_q      <= a;
      b_q      <= b;
    end else if (active_q) begin
      if (a_q == b_q)     active_q <= 1'b0;
      else if (a_q > b_q) a_q      <= a_q - b_q;
      else                b_q      <= b_q - a_q;
    end
  end

  assign done = active_q && (a_q == b_q);
  assign gcd  = a_q;

endmodule

// File: rtl/totient_sequencer.sv
// Sweeps n over [n_start, n_end], counting k in 1..n with gcd(k,n) == 1
// through one shared GCD engine, and presents phi(n) on a valid/ready port.
// The low nibble of each accepted phi is latched and shown on segments A..G.
// Ports:
//   clk_0, R            : clock, asynchronous active-high reset
//   start, n_start/end  : range request, sampled only when idle
//   busy, cfg_err       : not-idle flag, one-cycle pulse on a rejected range
//   phi_valid/ready     : result handshake; phi, phi_n held until accepted
//   A..G                : active-high seven-segment outputs
// Build option: TOTIENT_AUTOWRAP_EN restarts the range forever instead of
// returning to IDLE after the last n.
module totient_sequencer
  import totient_pkg::*;
#(
  parameter int N_W = TOT_N_W
) (
  input  logic           clk_0,
  input  logic           R,
  input  logic           start,
  input  logic [N_W-1:0] n_start,
  input  logic [N_W-1:0] n_end,
  output logic           busy,
  output logic           cfg_err,
  output logic           phi_valid,
  input  logic           phi_ready,
  output logic [N_W-1:0] phi,
  output logic [N_W-1:0] phi_n,
  output logic           A, B, C, D, E, F, G
);

  state_e         state_q, state_d;
  logic [N_W-1:0] n_q, n_d, nend_q, nend_d, k_q, k_d, cnt_q, cnt_d;
  logic [3:0]     disp_q, disp_d;
  logic           cfg_err_q, cfg_err_d;
`ifdef TOTIENT_AUTOWRAP_EN
  logic [N_W-1:0] nstart_q, nstart_d;
`endif

  logic           gcd_start, gcd_done;
  logic [N_W-1:0] gcd_val;

  totient_gcd_unit #(.N_W(N_W)) u_gcd (
    .clk_0 (clk_0),
    .R     (R),
    .start (gcd_start),
    .a     (k_q),
    .b     (n_q),
    .done  (gcd_done),
    .gcd   (gcd_val)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    nend_d    = nend_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    cfg_err_d = 1'b0;
    gcd_start = 1'b0;
`ifdef TOTIENT_AUTOWRAP_EN
    nstart_d  = nstart_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_start == '0 || n_start > n_end) begin
            cfg_err_d = 1'b1;
          end else begin
            n_d     = n_start;
            nend_d  = n_end;
            k_d     = N_W'(1);
            cnt_d   = '0;
            state_d = ISSUE;
`ifdef TOTIENT_AUTOWRAP_EN
            nstart_d = n_start;
`endif
          end
        end
      end
      ISSUE: begin
        gcd_start = 1'b1;
        state_d   = WAIT_GCD;
      end
      WAIT_GCD: begin
        if (gcd_done) begin
          if (gcd_val == N_W'(1)) cnt_d = cnt_q + 1'b1;
          if (k_q == n_q) begin
            state_d = EMIT;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      EMIT: begin
        if (phi_ready) begin
          disp_d = cnt_q[3:0];
          k_d    = N_W'(1);
          cnt_d  = '0;
          // Compare before incrementing so n never wraps past the top value.
          if (n_q == nend_q) begin
`ifdef TOTIENT_AUTOWRAP_EN
            n_d     = nstart_q;
            state_d = ISSUE;
`else
            state_d = IDLE;
`endif
          end else begin
            n_d     = n_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or posedge R) begin
    if (R) begin
      state_q   <= IDLE;
      n_q       <= '0;
      nend_q    <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      cfg_err_q <= 1'b0;
`ifdef TOTIENT_AUTOWRAP_EN
      nstart_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      nend_q    <= nend_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      cfg_err_q <= cfg_err_d;
`ifdef TOTIENT_AUTOWRAP_EN
      nstart_q  <= nstart_d;
`endif
    end
  end

  // cnt and n only change on a handshake while in EMIT, so they double as
  // the held result registers.
  assign busy      = (state_q != IDLE);
  assign cfg_err   = cfg_err_q;
  assign phi_valid = (state_q == EMIT);
  assign phi       = cnt_q;
  assign phi_n     = n_q;
  assign {A, B, C, D, E, F, G} = SEG_TBL[disp_q];

endmodule

// File: tb/tb_totient_sequencer.sv
module tb_totient_sequencer;

  localparam int W = 5;

  logic         clk_0 = 1'b0;
  logic         R, start, phi_ready;
  logic [W-1:0] n_start, n_end;
  logic         busy, cfg_err, phi_valid;
  logic [W-1:0] phi, phi_n;
  logic         A, B, C, D, E, F, G;
  logic [6:0]   seg;

  assign seg = {A, B, C, D, E, F, G};

  always #5 clk_0 = ~clk_0;

  totient_sequencer #(.N_W(W)) dut (
    .clk_0(clk_0), .R(R), .start(start), .n_start(n_start), .n_end(n_end),
    .busy(busy), .cfg_err(cfg_err), .phi_valid(phi_valid), .phi_ready(phi_ready),
    .phi(phi), .phi_n(phi_n), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
  );

  typedef struct packed {
    logic [W-1:0] phi;
    logic [W-1:0] n;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted result must match the oldest expectation.
  always @(negedge clk_0) begin
    if (!R && phi_valid && phi_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", phi_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("phi", phi, e.phi);
        chk("phi_n", phi_n, e.n);
      end
    end
  end

  // Inputs change 1 time unit after a rising edge; start is high for one edge.
  task automatic do_start(input logic [W-1:0] s, input logic [W-1:0] e);
    n_start = s;
    n_end   = e;
    start   = 1'b1;
    @(posedge clk_0); #1;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_0);
      if (!busy) break;
    end
    chk(nm, busy, 1'b0);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_0);
      if (phi_valid) break;
    end
    chk(nm, phi_valid, 1'b1);
  endtask

  task automatic push(input logic [W-1:0] p, input logic [W-1:0] n);
    exp_t e;
    e.phi = p;
    e.n   = n;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [W-1:0] phi_tbl [16];
    logic         held;
    phi_tbl = '{1, 1, 2, 2, 4, 2, 6, 4, 6, 4, 10, 4, 12, 6, 8, 8};

    R = 1'b1; start = 1'b0; phi_ready = 1'b0; n_start = '0; n_end = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_valid", phi_valid, 1'b0);
    chk("rst_phi", phi, 0);
    chk("rst_phi_n", phi_n, 0);
    chk("rst_seg", seg, 7'b1111110);
    @(posedge clk_0); #1;
    R = 1'b0;

`ifdef TOTIENT_AUTOWRAP_EN
    // Range 5..6 wraps forever; stop it with reset after a few laps.
    phi_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(4, 5);
      push(2, 6);
    end
    do_start(5, 6);
    repeat (3) @(posedge clk_0);
    #1;
    do_start(1, 1);
    @(negedge clk_0);
    chk("wrap_busy_start_ignored", busy, 1'b1);
    chk("wrap_no_cfg_err", cfg_err, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk_0);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk("wrap_results_seen", exp_q.size(), 0);
    chk("wrap_still_busy", busy, 1'b1);
    chk("wrap_seg_last_2", seg, 7'b1101101);
    R = 1'b1;
    #1;
    chk("wrap_rst_busy", busy, 1'b0);
    @(posedge clk_0); #1;
    R = 1'b0;
`else
    // Full sweep 1..16 with ready held high.
    phi_ready = 1'b1;
    for (int n = 1; n <= 16; n++) push(phi_tbl[n-1], W'(n));
    do_start(1, 16);
    repeat (2) @(posedge clk_0);
    #1;
    do_start(0, 5);  // rejected range, but ignored because busy
    @(negedge clk_0);
    chk("busy_start_no_cfg_err", cfg_err, 1'b0);
    chk("busy_start_still_busy", busy, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_0);
      if (phi_valid && phi_n == W'(11)) break;
    end
    chk("reach_n11", phi_n, 11);
    @(negedge clk_0);
    chk("valid_one_cycle", phi_valid, 1'b0);
    chk("seg_after_11", seg, 7'b1110111);
    wait_idle("sweep_idle");
    chk("sweep_queue_empty", exp_q.size(), 0);
    chk("seg_after_16", seg, 7'b1111111);

    // n = 1 latency: valid appears on the third cycle after the start edge.
    push(1, 1);
    do_start(1, 1);
    @(negedge clk_0);
    chk("lat_c1_valid", phi_valid, 1'b0);
    @(negedge clk_0);
    chk("lat_c2_valid", phi_valid, 1'b0);
    @(negedge clk_0);
    chk("lat_c3_valid", phi_valid, 1'b1);
    wait_idle("n1_idle");
    chk("seg_after_1", seg, 7'b0110000);

    // Back-pressure: result held stable with ready low.
    phi_ready = 1'b0;
    push(6, 7);
    do_start(7, 7);
    wait_valid("hold_valid");
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_0);
      if (!(phi_valid && phi == W'(6) && phi_n == W'(7) && seg == 7'b0110000)) held = 1'b0;
    end
    chk("hold_stable", held, 1'b1);
    @(posedge clk_0); #1;
    phi_ready = 1'b1;
    @(negedge clk_0);
    chk("seg_before_accept", seg, 7'b0110000);
    @(negedge clk_0);
    chk("seg_after_7", seg, 7'b1011111);
    chk("hold_idle", busy, 1'b0);

    // Rejected ranges.
    do_start(9, 3);
    @(negedge clk_0);
    chk("cfg_err_rev", cfg_err, 1'b1);
    chk("cfg_err_rev_busy", busy, 1'b0);
    @(negedge clk_0);
    chk("cfg_err_rev_pulse", cfg_err, 1'b0);
    do_start(0, 5);
    @(negedge clk_0);
    chk("cfg_err_zero", cfg_err, 1'b1);
    chk("cfg_err_zero_busy", busy, 1'b0);
    @(negedge clk_0);
    chk("cfg_err_zero_pulse", cfg_err, 1'b0);

    // Asynchronous reset mid-computation, then a clean rerun.
    do_start(13, 13);
    repeat (6) @(negedge clk_0);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    R = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", phi_valid, 1'b0);
    chk("arst_phi", phi, 0);
    chk("arst_phi_n", phi_n, 0);
    chk("arst_seg", seg, 7'b1111110);
    @(posedge clk_0); #1;
    R = 1'b0;
    push(12, 13);
    do_start(13, 13);
    wait_idle("n13_idle");
    chk("seg_after_13", seg, 7'b1001110);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/totient_sequencer.md
# totient_sequencer

- Controller that schedules the Euler-totient datapath over a range of n.
- For each n in [n_start, n_end], steps k = 1..n through a shared iterative subtractive GCD engine and counts the k with gcd(k,n) = 1.
- Presents each φ(n) on a valid/ready result port and latches the last accepted value onto the seven-segment outputs A..G.
- Sits between the board control logic (start, range select) and the display.

## Interface
Parameters:
- N_W, 5: width of n, k, count and φ; legal n = 1..2^N_W−1.

Ports:
- clk_0  in  1  system clock, all state on rising edge.
- R  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- n_start  in  N_W  first n; sampled with start.
- n_end  in  N_W  last n; sampled with start.
- busy  out  1  high in any state but IDLE.
- cfg_err  out  1  one-cycle pulse on a rejected start.
- phi_valid  out  1  result available.
- phi_ready  in  1  consumer accepts result.
- phi  out  N_W  φ(n).
- phi_n  out  N_W  the n that phi belongs to.
- A, B, C, D, E, F, G  out  1 each  active-high segments (1 = lit) showing hex of phi[3:0] of the last accepted result.

## Operation
FSM states: IDLE, ISSUE, WAIT_GCD, EMIT.
- **IDLE**
  - start with n_start = 0, or n_start > n_end: pulse cfg_err next cycle and stay in IDLE.
  - Otherwise latch n = n_start and n_end, set k = 1, cnt = 0, go to ISSUE.
- **ISSUE**: drive gcd_start for one cycle with (a = k, b = n); go to WAIT_GCD.
- **WAIT_GCD**: on gcd_done:
  - If gcd == 1, cnt increments.
  - If k == n, go to EMIT; else k increments and go to ISSUE.
- **EMIT**
  - phi_valid = 1, phi = cnt (including the final increment), phi_n = n.
  - phi and phi_n are held stable until phi_valid·phi_ready.
  - On handshake:
    - The display register loads phi[3:0].
    - If n == n_end, go to IDLE; else n increments, k = 1, cnt = 0, go to ISSUE.
- **GCD engine**
  - On gcd_start it loads a and b.
  - While active, each cycle: if a > b then a −= b; if b > a then b −= a.
  - gcd_done is combinational, high while active and a == b; gcd = a.
  - The engine goes inactive on the cycle after done.
- **Arithmetic**
  - The comparison n == n_end is made before incrementing, so n never overflows.
  - cnt ≤ n, so N_W bits suffice.
- **Other rules**
  - start while busy is ignored: no cfg_err, no state change.
  - phi_ready outside EMIT is ignored.
- **Segment patterns** (ABCDEFG), 0–F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.

## Timing
- **Reset (R high)**, asynchronous, any state:
  - state = IDLE, busy = 0, cfg_err = 0, phi_valid = 0, phi = 0, phi_n = 0.
  - Display register = 0, so ABCDEFG = 1111110.
  - Engine inactive; an in-flight computation is discarded.
- **Latency per k**: 1 cycle in ISSUE + (s+1) cycles in WAIT_GCD, where s = number of subtractions for (k,n).
  - For n = 1 with start sampled at edge 0: ISSUE at cycle 1, WAIT_GCD at cycle 2 (done, since a == b), phi_valid high from cycle 3.
- **After handshake**: the next n enters ISSUE on the following cycle; phi_valid drops for at least 2 cycles.
- **Ready held high**: phi_valid lasts exactly 1 cycle per result.
- **cfg_err**: high exactly one cycle, the cycle after the rejected start.

## Configuration
- TOTIENT_AUTOWRAP_EN defined: on the handshake with n == n_end, reload n = latched n_start, k = 1, cnt = 0, go to ISSUE. Runs forever until reset; busy stays 1.
- TOTIENT_AUTOWRAP_EN undefined: return to IDLE as described above.

## Structure
- Package totient_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_GCD, EMIT);
  - the 16-entry ABCDEFG segment constant table;
  - default N_W.
- Sub-module totient_gcd_unit (clk_0, R, start, a, b, done, gcd, N_W-parameterised) holds the subtractive engine. The sequencer instantiates exactly one.

## Test plan
- Reset, then start with n_start = 1, n_end = 16, phi_ready = 1 → phi sequence 1,1,2,2,4,2,6,4,6,4,10,4,12,6,8,8 with phi_n 1..16. After the 11th result ABCDEFG = 1110111 (A); busy falls after n = 16.
- n_start = n_end = 1 → phi_valid first high exactly 3 cycles after the start edge, phi = 1.
- n_start = 7, n_end = 7, phi_ready low for 20 cycles after phi_valid → phi = 6 and phi_n = 7 held stable. ABCDEFG unchanged until the ready cycle, then 1011111.
- start with n_start = 9, n_end = 3, and separately n_start = 0 → each gives one cfg_err pulse; busy stays 0.
- R asserted while in WAIT_GCD during n = 13 → all outputs reach reset values without a clock edge. A following start with range 13..13 yields φ = 12 (ABCDEFG = 1001110).
- With TOTIENT_AUTOWRAP_EN, range 5..6 → results 4,2,4,2,… continuously; start pulses during the run are ignored.
